intc_vec: RTL

//  Parametrised vectored interrupt controller. Drives the CPU's single INTin/INTnum pair.

---
 rtl/intc_vec_pkg.sv | 23 ++
 rtl/intc_vec_if.sv | 25 ++
 rtl/intc_prio_enc.sv | 24 ++
 rtl/intc_vec.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/intc_vec_pkg.sv
// Shared definitions for the vectored interrupt controller: register map, FSM states
// and the cause-code helper.
package intc_vec_pkg;

   localparam logic [1:0] REG_MASK      = 2'd0;
   localparam logic [1:0] REG_PENDING   = 2'd1;
   localparam logic [1:0] REG_INSERVICE = 2'd2;
   localparam logic [1:0] REG_SWTRIG    = 2'd3;

   localparam int IDX_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } intc_state_e;

   function automatic logic [31:0] cause_code(input logic [31:0] base,
                                              input logic [IDX_W-1:0] idx);
      return base + {27'b0, idx};
   endfunction

endpackage

// File: rtl/intc_vec_if.sv
// Bundle of interrupt sources, CPU handshake and register port for intc_vec.
// master = CPU/system side, slave = controller side.
interface intc_vec_if #(
   parameter int NCH = 8
);
   logic [NCH-1:0] irq_src;
   logic           INTin;
   logic [31:0]    INTnum;
   logic           int_ack;
   logic           int_eoi;
   logic           reg_we;
   logic [1:0]     reg_addr;
   logic [31:0]    reg_wdata;
   logic [31:0]    reg_rdata;

   modport master (
      output irq_src, int_ack, int_eoi, reg_we, reg_addr, reg_wdata,
      input  INTin, INTnum, reg_rdata
   );

   modport slave (
      input  irq_src, int_ack, int_eoi, reg_we, reg_addr, reg_wdata,
      output INTin, INTnum, reg_rdata
   );
endinterface

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: lowest set index of the eligible vector wins.
module intc_prio_enc
   import intc_vec_pkg::*;
#(
   parameter int NCH = 8
) (
   input  logic [NCH-1:0]   elig,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      any = 1'b0;
      idx = '0;
      // scan downwards so the lowest set bit is the last one written
      for (int i = NCH - 1; i >= 0; i--) begin
         if (elig[i]) begin
            any = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/intc_vec.sv
// Vectored interrupt controller: edge/level pending capture, mask, single-level
// request/ack/eoi sequencing toward the CPU, and the register file.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | no request outstanding; arbitrate eligible channels
//   ST_REQ     | INTin high, INTnum frozen on latched channel; wait for ack
//   ST_SERVICE | CPU servicing latched channel; wait for eoi
module intc_vec
   import intc_vec_pkg::*;
#(
   parameter int             NCH        = 8,
   parameter logic [31:0]    CAUSE_BASE = 32'h10,
   parameter logic [NCH-1:0] EDGE_MASK  = '1
) (
   input logic       clk,
   input logic       rst,
   intc_vec_if.slave bus
);

   intc_state_e      state_q, state_d;
   logic [NCH-1:0]   mask_q, mask_d;
   logic [NCH-1:0]   pend_q, pend_d;
   logic [NCH-1:0]   prev_q, prev_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             int_in_q, int_in_d;
   logic [31:0]      int_num_q, int_num_d;

   logic [NCH-1:0]   src;
   logic [NCH-1:0]   pend_vis;
   logic [NCH-1:0]   idx_onehot;
   logic [NCH-1:0]   insvc_vec;
   logic [NCH-1:0]   elig;
   logic [NCH-1:0]   rise;
   logic [NCH-1:0]   sw_set;
   logic [NCH-1:0]   w1c_clr;
   logic [NCH-1:0]   ack_clr;
   logic             wr_mask, wr_pend, wr_sw;
   logic             ack_take, eoi_take, latched_live;
   logic             enc_any;
   logic [IDX_W-1:0] enc_idx;
   logic [31:0]      rdata;

   assign src = bus.irq_src;

   assign wr_mask = bus.reg_we && (bus.reg_addr == REG_MASK);
   assign wr_pend = bus.reg_we && (bus.reg_addr == REG_PENDING);
   assign wr_sw   = bus.reg_we && (bus.reg_addr == REG_SWTRIG);

   assign ack_take = (state_q == ST_REQ) && bus.int_ack;
   // simultaneous ack+eoi is an ack, and an ack in SERVICE is ignored
   assign eoi_take = (state_q == ST_SERVICE) && bus.int_eoi && !bus.int_ack;

   always_comb begin
      idx_onehot = '0;
      idx_onehot = NCH'(1) << idx_q;
   end

   // level channels are transparent; edge channels come from the latch
   assign pend_vis     = (pend_q & EDGE_MASK) | (src & ~EDGE_MASK);
   assign insvc_vec    = (state_q == ST_SERVICE) ? idx_onehot : '0;
   assign elig         = pend_vis & mask_q & ~insvc_vec;
   assign latched_live = |(pend_vis & mask_q & idx_onehot);

   assign rise    = src & ~prev_q & EDGE_MASK;
   assign sw_set  = wr_sw   ? (bus.reg_wdata[NCH-1:0] & EDGE_MASK) : '0;
   assign w1c_clr = wr_pend ? bus.reg_wdata[NCH-1:0] : '0;
   assign ack_clr = ack_take ? idx_onehot : '0;

   intc_prio_enc #(.NCH(NCH)) u_prio_enc (
      .elig (elig),
      .any  (enc_any),
      .idx  (enc_idx)
   );

   always_comb begin
      prev_d = src;
      mask_d = wr_mask ? bus.reg_wdata[NCH-1:0] : mask_q;
      // set events are applied after clears so a coincident edge is never lost
      pend_d = ((pend_q & ~(w1c_clr | ack_clr)) | rise | sw_set) & EDGE_MASK;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      int_in_d  = int_in_q;
      int_num_d = int_num_q;
      unique case (state_q)
         ST_IDLE: begin
            if (enc_any) begin
               state_d   = ST_REQ;
               idx_d     = enc_idx;
               int_in_d  = 1'b1;
               int_num_d = cause_code(CAUSE_BASE, enc_idx);
            end
         end
         ST_REQ: begin
            if (ack_take) begin
               state_d  = ST_SERVICE;
               int_in_d = 1'b0;
            end else if (!latched_live) begin
               state_d  = ST_IDLE;
               int_in_d = 1'b0;
            end
         end
         ST_SERVICE: begin
            if (eoi_take) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            int_in_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mask_q    <= '0;
         pend_q    <= '0;
         prev_q    <= '0;
         idx_q     <= '0;
         int_in_q  <= 1'b0;
         int_num_q <= '0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         pend_q    <= pend_d;
         prev_q    <= prev_d;
         idx_q     <= idx_d;
         int_in_q  <= int_in_d;
         int_num_q <= int_num_d;
      end
   end

   always_comb begin
      rdata = '0;
      unique case (bus.reg_addr)
         REG_MASK:      rdata[NCH-1:0] = mask_q;
         REG_PENDING:   rdata[NCH-1:0] = pend_vis;
         REG_INSERVICE: begin
            if (state_q == ST_SERVICE) begin
               rdata[31]          = 1'b1;
               rdata[IDX_W-1:0]   = idx_q;
            end
         end
         default:       rdata = '0;
      endcase
   end

   assign bus.INTin     = int_in_q;
   assign bus.INTnum    = int_num_q;
   assign bus.reg_rdata = rdata;

endmodule
